fb_line_reader: RTL

FB_LINE_READER -- requirements
Module: fb_line_reader

---
 rtl/fb_pkg.sv | 17 +
 rtl/pipe_delay.sv | 34 +++
 rtl/fb_line_reader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and counter widths for the framebuffer line reader.
// The state encoding is shared so sub-blocks and benches can decode it.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } fb_state_e;

  // Column/row counters cover dimensions up to 1023; line counter up to 63.
  localparam int CNTW  = 10;
  localparam int LCNTW = 6;
  localparam int DRNW  = 2;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-latency shift pipeline with synchronous clear.
// Output equals the input delayed by exactly LAT clock cycles.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [LAT*WIDTH-1:0] sr_q;
  logic [LAT*WIDTH-1:0] sr_d;

  generate
    if (LAT == 1) begin : g_one
      always_comb sr_d = din;
    end else begin : g_many
      always_comb sr_d = {sr_q[(LAT-1)*WIDTH-1:0], din};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[LAT*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/fb_line_reader.sv
// Copies one framebuffer row into the linebuffer every FB_SCALE screen lines.
// Addresses stream one per cycle; write strobes trail them by the read latency.
module fb_line_reader
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 90,
  parameter int FB_SCALE  = 4,
  parameter int ADDRW     = 14,
  parameter int DATAW     = 2,
  parameter int RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame,
  input  logic             line,
  input  logic             line0,
  output logic [ADDRW-1:0] fb_addr,
  input  logic [DATAW-1:0] fb_data,
  output logic             lb_en,
  output logic [DATAW-1:0] lb_data,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam logic [CNTW-1:0]  COL_LAST   = CNTW'(FB_WIDTH - 1);
  localparam logic [CNTW-1:0]  ROW_LAST   = CNTW'(FB_HEIGHT - 1);
  localparam logic [LCNTW-1:0] LINE_LAST  = LCNTW'(FB_SCALE - 1);
  localparam logic [DRNW-1:0]  DRAIN_INIT = DRNW'(RD_LAT - 1);
  localparam logic [ADDRW-1:0] ROW_STEP   = ADDRW'(FB_WIDTH);

  fb_state_e        state_q, state_d;
  logic [CNTW-1:0]  row_q, row_d;
  logic [CNTW-1:0]  col_q, col_d;
  logic [LCNTW-1:0] line_cnt_q, line_cnt_d;
  logic [DRNW-1:0]  drain_q, drain_d;
  logic [ADDRW-1:0] base_q, base_d;
  logic [ADDRW-1:0] fb_addr_q, fb_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic [LCNTW-1:0] line_cnt_inc;
  logic             issue;
  logic             pipe_clr;

  assign line_cnt_inc = (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + LCNTW'(1);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    line_cnt_d = line_cnt_q;
    drain_d    = drain_q;
    base_d     = base_q;
    fb_addr_d  = fb_addr_q;
    done_d     = 1'b0;
    overrun_d  = 1'b0;

    if (frame) begin
      state_d    = ST_IDLE;
      row_d      = '0;
      col_d      = '0;
      line_cnt_d = '0;
      drain_d    = '0;
      base_d     = '0;
      fb_addr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (line0) begin
            state_d    = ST_FETCH;
            row_d      = '0;
            col_d      = '0;
            line_cnt_d = '0;
            base_d     = '0;
            fb_addr_d  = '0;
          end
        end

        ST_WAIT: begin
          if (line) begin
            line_cnt_d = line_cnt_inc;
            if (line_cnt_q == LINE_LAST) begin
              state_d   = ST_FETCH;
              col_d     = '0;
              fb_addr_d = base_q;
            end
          end
        end

        ST_FETCH: begin
          if (col_q == COL_LAST) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_INIT;
          end else begin
            col_d     = col_q + CNTW'(1);
            fb_addr_d = fb_addr_q + ADDRW'(1);
          end
          // A line during a fetch is reported but still counted, so the
          // screen-line cadence stays locked to the display.
          if (line) begin
            overrun_d  = 1'b1;
            line_cnt_d = line_cnt_inc;
          end
        end

        ST_DRAIN: begin
          if (drain_q == '0) begin
            if (row_q == ROW_LAST) begin
              state_d   = ST_IDLE;
              done_d    = 1'b1;
              row_d     = '0;
              base_d    = '0;
              fb_addr_d = '0;
            end else begin
              state_d = ST_WAIT;
              row_d   = row_q + CNTW'(1);
              base_d  = base_q + ROW_STEP;
            end
          end else begin
            drain_d = drain_q - DRNW'(1);
          end
          if (line) begin
            overrun_d  = 1'b1;
            line_cnt_d = line_cnt_inc;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      line_cnt_q <= '0;
      drain_q    <= '0;
      base_q     <= '0;
      fb_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      line_cnt_q <= line_cnt_d;
      drain_q    <= drain_d;
      base_q     <= base_d;
      fb_addr_q  <= fb_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  // Each FETCH cycle puts one address on the bus; its data returns RD_LAT later.
  assign issue    = (state_q == ST_FETCH);
  assign pipe_clr = !rst_n || frame;

  pipe_delay #(
    .WIDTH (1),
    .LAT   (RD_LAT)
  ) u_en_delay (
    .clk  (clk),
    .clr  (pipe_clr),
    .din  (issue),
    .dout (lb_en)
  );

  assign lb_data = lb_en ? fb_data : '0;
  assign fb_addr = fb_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
